// File: rtl/router_pkg.sv
// Shared constants for the router packet path: default sizing and header field layout.
// Header byte: addr in the low ADDR_W bits, length in the remaining upper bits.
package router_pkg;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int ADDR_W       = 2;
  localparam int LEN_LSB      = ADDR_W;
  localparam int PKT_OVERHEAD = 2;
endpackage

// File: rtl/router_pkt_len_ctr.sv
// Packet length down-counter: load on header, decrement per byte, flag the byte that ends a packet.
// Zero-latency done flag (combinational); state updates on the clock edge.
module router_pkt_len_ctr #(
  parameter int W = 7
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt;

  // A load always wins: a header mid-packet restarts the count.
  assign done = dec && !load && !clear && (cnt == W'(1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/router_pkt_fifo.sv
// Router packet FIFO storing {header flag, byte}; tracks complete packets held and flags packet ends on read.
// Registered read data (1-cycle); full rejects writes unless a read frees a slot, empty rejects reads.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_LVL = DEPTH - 2,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  pkt_count,
  output logic              pkt_last,
  output logic              overflow,
  output logic              underflow
);

  localparam int LEN_W = DATA_W - LEN_LSB + 1;

  logic [DATA_W:0]   mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W:0]   rd_entry;
  logic              wr_acc;
  logic              rd_acc;
  logic              wr_done;
  logic              rd_done;
  logic              pkt_inc;
  logic              pkt_dec;
  logic [LEN_W-1:0]  wr_len_val;
  logic [LEN_W-1:0]  rd_len_val;

  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(DEPTH));
  assign almost_full = (count >= CNT_W'(AFULL_LVL));

  // When full, a same-cycle read frees the slot the write lands in.
  assign wr_acc   = write_enb && (!full || read_enb);
  assign rd_acc   = read_enb && !empty;
  assign rd_entry = mem[rd_ptr];

  assign wr_len_val = LEN_W'(data_in[DATA_W-1:LEN_LSB]) + LEN_W'(PKT_OVERHEAD - 1);
  assign rd_len_val = LEN_W'(rd_entry[DATA_W-1:LEN_LSB]) + LEN_W'(PKT_OVERHEAD - 1);

  router_pkt_len_ctr #(.W(LEN_W)) u_wr_len (
    .clock    (clock),
    .resetn   (resetn),
    .clear    (soft_reset),
    .load     (wr_acc && lfd_state),
    .load_val (wr_len_val),
    .dec      (wr_acc && !lfd_state),
    .done     (wr_done)
  );

  router_pkt_len_ctr #(.W(LEN_W)) u_rd_len (
    .clock    (clock),
    .resetn   (resetn),
    .clear    (soft_reset),
    .load     (rd_acc && rd_entry[DATA_W]),
    .load_val (rd_len_val),
    .dec      (rd_acc && !rd_entry[DATA_W]),
    .done     (rd_done)
  );

  assign pkt_inc = wr_done;
  assign pkt_dec = rd_done && (pkt_count != '0);

  always_ff @(posedge clock) begin
    if (wr_acc && !soft_reset) begin
      mem[wr_ptr] <= {lfd_state, data_in};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_count <= '0;
      data_out  <= '0;
      pkt_last  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_count <= '0;
      data_out  <= '0;
      pkt_last  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= write_enb && !wr_acc;
      // A write into an empty FIFO absorbs the same-cycle read request.
      underflow <= read_enb && empty && !wr_acc;
      pkt_last  <= rd_done;

      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        data_out <= rd_entry[DATA_W-1:0];
      end

      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      case ({pkt_inc, pkt_dec})
        2'b10:   pkt_count <= pkt_count + CNT_W'(1);
        2'b01:   pkt_count <= pkt_count - CNT_W'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule

// File: doc/router_pkt_fifo.md
ROUTER_PKT_FIFO -- requirements
Module: router_pkt_fifo

Interface
REQ-001 Parameter DATA_W, default 8, byte width of stored data; SHALL be >= 8.
REQ-002 Parameter DEPTH, default 16, entry count; SHALL be a power of two, >= 4.
REQ-003 Parameter AFULL_LVL, default DEPTH-2, occupancy at which almost_full asserts.
REQ-004 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 soft_reset  in  1  synchronous flush, active high.
REQ-007 write_enb  in  1  write request.
REQ-008 read_enb  in  1  read request.
REQ-009 lfd_state  in  1  marks data_in as a packet header byte.
REQ-010 data_in  in  DATA_W  write data.
REQ-011 data_out  out  DATA_W  registered read data.
REQ-012 empty / full  out  1 each  occupancy == 0 / == DEPTH.
REQ-013 almost_full  out  1  occupancy >= AFULL_LVL.
REQ-014 count  out  clog2(DEPTH)+1  current occupancy.
REQ-015 pkt_count  out  clog2(DEPTH)+1  complete packets currently stored.
REQ-016 pkt_last  out  1  one-cycle pulse: last byte (parity) of a packet was read.
REQ-017 overflow / underflow  out  1 each  one-cycle pulse on rejected write / read.

Function
REQ-018 Each entry SHALL store {lfd_state, data_in} (DATA_W+1 bits).
REQ-019 Write accepted iff write_enb && (!full || read_enb); rejected write SHALL pulse overflow, no state change.
REQ-020 Read accepted iff read_enb && !empty; rejected read SHALL pulse underflow, data_out holds.
REQ-021 Simultaneous accepted read+write SHALL leave count unchanged; when empty, write accepted, read rejected (no underflow pulse).
REQ-022 Read latency: data_out SHALL show the popped byte after the same edge that accepts the read; otherwise data_out holds.
REQ-023 Pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-024 Header length field = data[DATA_W-1:2]; packet size = length + 2 (header, payload, parity).
REQ-025 Write-side length counter: on accepted write with lfd_state=1, load length+1; decrement per accepted non-header write; write bringing it to 0 SHALL increment pkt_count.
REQ-026 Read-side length counter: on read of entry with lfd flag, load length+1; decrement per subsequent read; read bringing it to 0 SHALL pulse pkt_last next cycle-aligned with data_out and decrement pkt_count.
REQ-027 Simultaneous pkt_count increment and decrement SHALL leave pkt_count unchanged.
REQ-028 Header with length 0 SHALL be a 2-byte packet (header, parity).
REQ-029 Header written while a write packet is incomplete SHALL restart the write counter; the abandoned packet is not counted.
REQ-030 soft_reset SHALL, at the edge, clear pointers, count, pkt_count, both length counters, data_out=0, pulses=0; it overrides same-cycle read/write.

Reset
REQ-031 resetn low SHALL immediately force data_out=0, count=0, pkt_count=0, empty=1, full=0, almost_full=0, pkt_last=0, overflow=0, underflow=0, pointers and counters 0.
REQ-032 Storage array contents need not be reset; no output SHALL depend on unwritten entries.
REQ-033 Reset mid-packet SHALL discard all partial packets; first accepted write after reset is treated per its lfd_state.

Structure
REQ-034 Package router_pkg SHALL hold default DATA_W/DEPTH, header field positions (addr [1:0], length [DATA_W-1:2]) and the packet-overhead constant 2.
REQ-035 One sub-module router_pkt_len_ctr (load/decrement/zero-detect) SHALL be instantiated twice, write side and read side.

Verification
REQ-036 Reset, write header 0x39 (len 14) + 14 payload + parity -> count=16, full=1, almost_full=1, pkt_count=1.
REQ-037 From REQ-036, read 16 times -> bytes in write order, one cycle latency, pkt_last on 16th read, pkt_count=0, empty=1.
REQ-038 Full FIFO, write_enb=1 read_enb=0 -> overflow pulse, count stays 16; then both asserted -> count stays 16, pointers wrap to 0.
REQ-039 Empty FIFO, read_enb=1 -> underflow pulse, data_out unchanged; write+read same cycle -> count=1, no underflow.
REQ-040 Write 5 bytes of packet (header 0x0C), assert soft_reset with write_enb=1 -> count=0, pkt_count=0, data_out=0, empty=1.
REQ-041 Two back-to-back packets (headers 0x00, 0x05), resetn low mid-second packet -> all outputs at REQ-031 values asynchronously.
